// File: rtl/router_reg_gen.sv
// Datapath register stage of the multi-channel router: header capture, full-FIFO
// byte holding, FIFO write data, and per-packet parity / length checking.
module router_reg_gen #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2,
  parameter int LEN_W  = DATA_W - ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err,
  output logic              addr_err
);

  // Handshake: pkt_valid qualifies data_in (low on the trailing parity byte);
  // there is no ready -- back-pressure arrives as fifo_full plus the FSM decodes.

  localparam logic [ADDR_W:0] NUM_CH_V = (ADDR_W + 1)'(NUM_CH);

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] hold;
  logic              hold_is_par;
  logic [DATA_W-1:0] int_par;
  logic [DATA_W-1:0] pkt_par;
  logic [LEN_W-1:0]  count;
  logic              cnt_ovf;
  logic [DATA_W-1:0] dout_nxt;

  logic addr_ok;
  logic hdr_load;
  logic addr_bad;
  logic data_step;
  logic hold_step;
  logic pay_event;
  logic par_from_data;
  logic par_from_hold;
  logic [LEN_W-1:0] hdr_len;

  assign addr_ok       = {1'b0, data_in[ADDR_W-1:0]} < NUM_CH_V;
  assign hdr_load      = detect_add & pkt_valid & addr_ok;
  assign addr_bad      = detect_add & pkt_valid & ~addr_ok;
  assign data_step     = ld_state & ~fifo_full & pkt_valid;
  assign hold_step     = laf_state & ~hold_is_par;
  assign pay_event     = data_step | hold_step;
  assign par_from_data = ld_state & ~pkt_valid & ~fifo_full;
  assign par_from_hold = laf_state & hold_is_par;
  assign hdr_len       = header[DATA_W-1:ADDR_W];

  always_comb begin
    dout_nxt = dout;
    if (hdr_load)
      dout_nxt = dout;
    else if (lfd_state)
      dout_nxt = header;
    else if (ld_state & ~fifo_full)
      dout_nxt = data_in;
    else if (full_state)
      dout_nxt = dout;
    else if (laf_state)
      dout_nxt = hold;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      header   <= '0;
      dout     <= '0;
      addr_err <= 1'b0;
    end else begin
      if (hdr_load)
        header <= data_in;
      dout     <= dout_nxt;
      addr_err <= addr_bad;
    end
  end

  // A byte refused by a full FIFO is parked here and replayed in laf_state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold        <= '0;
      hold_is_par <= 1'b0;
    end else if (detect_add) begin
      hold        <= '0;
      hold_is_par <= 1'b0;
    end else if (ld_state & fifo_full) begin
      hold        <= data_in;
      hold_is_par <= ~pkt_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      int_par <= '0;
    end else if (detect_add) begin
      int_par <= '0;
    end else if (lfd_state) begin
      int_par <= header;
    end else if (data_step) begin
      int_par <= int_par ^ data_in;
    end else if (hold_step) begin
      int_par <= int_par ^ hold;
    end
  end

  // Counter saturates; cnt_ovf remembers a byte beyond all-ones so an overlong
  // packet at maximum length still flags len_err.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      cnt_ovf <= 1'b0;
    end else if (detect_add) begin
      count   <= '0;
      cnt_ovf <= 1'b0;
    end else if (pay_event) begin
      if (count != {LEN_W{1'b1}})
        count <= count + LEN_W'(1);
      else
        cnt_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_par     <= '0;
      parity_done <= 1'b0;
    end else begin
      parity_done <= par_from_data | par_from_hold;
      if (detect_add)
        pkt_par <= '0;
      else if (par_from_data)
        pkt_par <= data_in;
      else if (par_from_hold)
        pkt_par <= hold;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else if (detect_add) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else if (parity_done) begin
      err     <= (pkt_par != int_par);
      len_err <= (count != hdr_len) | cnt_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      low_pkt_valid <= 1'b0;
    else if (rst_int_reg | detect_add)
      low_pkt_valid <= 1'b0;
    else if (ld_state & ~pkt_valid)
      low_pkt_valid <= 1'b1;
  end

endmodule

// File: tb/tb_router_reg_gen.sv
// Bench for router_reg_gen: drives FSM-style packet sequences and checks against
// a packet-level model (expected write stream, parity and length outcome).
module tb_router_reg_gen;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              rst_int_reg;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic              len_err;
  logic              addr_err;

  router_reg_gen #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .dout(dout), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .len_err(len_err), .addr_err(addr_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] pay_q[$];
  logic [DATA_W-1:0] last_dout;
  logic [DATA_W-1:0] last_hdr;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pkt_valid   = 1'b0;
    data_in     = DATA_W'($urandom_range(0, 255));
    fifo_full   = 1'b0;
    rst_int_reg = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic write_check(input string tag);
    if (exp_q.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, dout);
    end else begin
      last_dout = exp_q.pop_front();
      chk(tag, dout, last_dout);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_pdone"}, parity_done, 0);
    chk({tag, "_lpv"}, low_pkt_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_lenerr"}, len_err, 0);
    chk({tag, "_addrerr"}, addr_err, 0);
  endtask

  // Drives one packet (header, pay_q, parity) the way the router FSM would.
  // full_idx selects which byte (payload index, or n for parity) meets a full FIFO.
  task automatic send_packet(input logic [DATA_W-1:0] hdr, input logic [DATA_W-1:0] par,
                             input int full_idx, input int full_cycles);
    int n;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] b;
    logic e_err;
    logic e_len;
    n = pay_q.size();
    x = hdr;
    foreach (pay_q[i]) x = x ^ pay_q[i];
    e_err = (x != par);
    e_len = (n != int'(hdr[DATA_W-1:ADDR_W]));
    exp_q = {};
    exp_q.push_back(hdr);
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    exp_q.push_back(par);

    idle_inputs();
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
    tick();
    chk("det_dout", dout, last_dout);
    chk("det_err_clr", err, 0);
    chk("det_lenerr_clr", len_err, 0);
    chk("det_addrerr", addr_err, 0);
    chk("det_lpv", low_pkt_valid, 0);
    last_hdr = hdr;

    idle_inputs();
    lfd_state = 1'b1; pkt_valid = 1'b1;
    tick();
    write_check("lfd_dout");

    for (int i = 0; i <= n; i++) begin
      b = (i < n) ? pay_q[i] : par;
      idle_inputs();
      ld_state = 1'b1; pkt_valid = (i < n); data_in = b;
      if (i == full_idx) begin
        fifo_full = 1'b1;
        tick();
        chk("full_hold", dout, last_dout);
        for (int k = 0; k < full_cycles; k++) begin
          idle_inputs();
          full_state = 1'b1; fifo_full = 1'b1;
          tick();
          chk("fst_hold", dout, last_dout);
        end
        idle_inputs();
        laf_state = 1'b1;
        tick();
        write_check("laf_dout");
      end else begin
        tick();
        write_check("ld_dout");
      end
      if (i < n) chk("pdone_early", parity_done, 0);
    end

    idle_inputs();
    chk("pdone_pulse", parity_done, 1);
    chk("lpv_set", low_pkt_valid, 1);
    tick();
    chk("pdone_fall", parity_done, 0);
    chk("err", err, e_err);
    chk("len_err", len_err, e_len);
    tick();
    chk("err_sticky", err, e_err);
    chk("lpv_held", low_pkt_valid, 1);
    rst_int_reg = 1'b1;
    tick();
    chk("lpv_clr", low_pkt_valid, 0);
    chk("len_err_sticky", len_err, e_len);
    rst_int_reg = 1'b0;
  endtask

  initial begin
    int len;
    int n;
    int fi;
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] par;

    // reset
    idle_inputs();
    reset = 1'b0;
    last_dout = '0;
    last_hdr = '0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b1;

    // clean packet
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h0D, 8'h0D, -1, 0);
    // bad parity byte
    send_packet(8'h0D, 8'h0E, -1, 0);
    // short payload with matching parity
    pay_q = '{8'h11, 8'h22};
    send_packet(8'h0D, 8'h3E, -1, 0);

    // invalid address: header keeps previous value
    idle_inputs();
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h07;
    tick();
    chk("inv_addrerr", addr_err, 1);
    chk("inv_dout", dout, last_dout);
    idle_inputs();
    lfd_state = 1'b1;
    tick();
    chk("inv_addrerr_fall", addr_err, 0);
    chk("inv_hdr_kept", dout, last_hdr);
    last_dout = last_hdr;
    idle_inputs();
    tick();

    // FIFO full on a payload byte, then on the parity byte
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h0D, 8'h0D, 1, 2);
    send_packet(8'h0D, 8'h0D, 3, 1);

    // zero-length packet
    pay_q = {};
    send_packet(8'h01, 8'h01, -1, 0);

    // maximum length, exact then one byte over
    pay_q = {};
    for (int i = 0; i < 63; i++) pay_q.push_back(DATA_W'($urandom_range(0, 255)));
    hdr = 8'hFE;
    par = hdr;
    foreach (pay_q[i]) par = par ^ pay_q[i];
    send_packet(hdr, par, -1, 0);
    pay_q.push_back(8'h5A);
    par = par ^ 8'h5A;
    send_packet(hdr, par, -1, 0);

    // reset in the middle of a payload
    idle_inputs();
    detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D;
    tick();
    idle_inputs(); lfd_state = 1'b1; pkt_valid = 1'b1;
    tick();
    idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h11;
    tick();
    idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h22;
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
    check_all_zero("midrst");
    reset = 1'b1;
    last_dout = '0;
    tick();
    chk("midrst_err_idle", err, 0);
    chk("midrst_lenerr_idle", len_err, 0);
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_packet(8'h0D, 8'h0D, -1, 0);

    // randomized packets
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(0, 10);
      n = len;
      if ($urandom_range(0, 4) == 0) n = len + 1;
      else if (len > 0 && $urandom_range(0, 4) == 0) n = len - 1;
      pay_q = {};
      for (int i = 0; i < n; i++) pay_q.push_back(DATA_W'($urandom_range(0, 255)));
      hdr = {6'(len), 2'($urandom_range(0, NUM_CH - 1))};
      par = hdr;
      foreach (pay_q[i]) par = par ^ pay_q[i];
      if ($urandom_range(0, 3) == 0) par = par ^ DATA_W'($urandom_range(1, 255));
      fi = $urandom_range(0, n + 3);
      send_packet(hdr, par, fi, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
